// File: rtl/druaga_pkg.sv
// Shared types and constants for the Druaga ROM download and core reset sequencing.
package druaga_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_e;

    localparam logic [7:0] ROM_INDEX = 8'd0;
    localparam logic [7:0] TNO_INDEX = 8'd1;
    localparam logic [7:0] DIP_INDEX = 8'd254;

    localparam int TNO_W  = 4;
    localparam int DSW_W  = 24;
    localparam int ADDR_W = 25;

endpackage

// File: rtl/rom_load_sequencer_if.sv
// HPS download stream in, core ROM write port out.
interface rom_load_sequencer_if;
    import druaga_pkg::*;

    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_index;

    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  rom_we, rom_addr, rom_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output rom_we, rom_addr, rom_data
    );

endinterface

// File: rtl/rom_load_sequencer.sv
// Routes downloaded ROM/title/DIP bytes to the game core and holds the core in
// reset until a ROM set is present and a settle window has elapsed.
//
//   state  | meaning
//   EMPTY  | no ROM loaded since RESET, core held in reset
//   LOAD   | download session in progress, core held in reset
//   SETTLE | ROM present, counting out the settle window
//   RUN    | core released
module rom_load_sequencer
    import druaga_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_TNO       = 5
) (
    input  logic                 clk_sys,
    input  logic                 RESET,
    rom_load_sequencer_if.slave  bus,
    input  logic                 user_rst,
    output logic [TNO_W-1:0]     tno,
    output logic [DSW_W-1:0]     dsw,
    output logic                 core_rst,
    output logic                 ready,
    output logic                 load_err,
    output logic [ADDR_W-1:0]    rom_bytes
);

    localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TNO_W-1:0] MAX_TNO_L = TNO_W'(MAX_TNO);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rom_we_q, rom_we_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [7:0]         rom_data_q, rom_data_d;
    logic [TNO_W-1:0]   tno_q, tno_d;
    logic [DSW_W-1:0]   dsw_q, dsw_d;
    logic               core_rst_q, core_rst_d;
    logic               ready_q, ready_d;
    logic               load_err_q, load_err_d;
    logic [ADDR_W-1:0]  rom_bytes_q, rom_bytes_d;
    logic               rom_loaded_q, rom_loaded_d;

    logic accept, rom_hit, tno_hit, dip_hit, load_entry;

    assign accept  = bus.ioctl_wr & bus.ioctl_download;
    assign rom_hit = accept && (bus.ioctl_index == ROM_INDEX);
    assign tno_hit = accept && (bus.ioctl_index == TNO_INDEX);
    assign dip_hit = accept && (bus.ioctl_index == DIP_INDEX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY: begin
                if (bus.ioctl_download) state_d = LOAD;
            end
            LOAD: begin
                if (!bus.ioctl_download) begin
                    state_d = rom_loaded_q ? SETTLE : EMPTY;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (bus.ioctl_download) begin
                    state_d = LOAD;
                end else if (user_rst) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (bus.ioctl_download) begin
                    state_d = LOAD;
                end else if (user_rst) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign load_entry = (state_d == LOAD) && (state_q != LOAD);

    // A byte accepted on the LOAD entry edge counts toward the new session.
    always_comb begin
        rom_we_d     = rom_hit;
        rom_addr_d   = rom_hit ? bus.ioctl_addr : rom_addr_q;
        rom_data_d   = rom_hit ? bus.ioctl_dout : rom_data_q;
        rom_loaded_d = rom_loaded_q | rom_hit;
        rom_bytes_d  = load_entry ? '0 : rom_bytes_q;
        if (rom_hit && (rom_bytes_d != '1)) rom_bytes_d = rom_bytes_d + ADDR_W'(1);

        load_err_d = load_entry ? 1'b0 : load_err_q;
        tno_d      = tno_q;
        if (tno_hit) begin
            if (bus.ioctl_dout[TNO_W-1:0] <= MAX_TNO_L) begin
                tno_d = bus.ioctl_dout[TNO_W-1:0];
            end else begin
                tno_d      = '0;
                load_err_d = 1'b1;
            end
        end

        dsw_d = dsw_q;
        if (dip_hit) begin
            case (bus.ioctl_addr)
                ADDR_W'(0): dsw_d[7:0]   = bus.ioctl_dout;
                ADDR_W'(1): dsw_d[15:8]  = bus.ioctl_dout;
                ADDR_W'(2): dsw_d[23:16] = bus.ioctl_dout;
                default:    dsw_d        = dsw_q;
            endcase
        end

        core_rst_d = (state_d != RUN);
        ready_d    = (state_d == RUN);
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q      <= EMPTY;
            cnt_q        <= '0;
            rom_we_q     <= 1'b0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            tno_q        <= '0;
            dsw_q        <= '0;
            core_rst_q   <= 1'b1;
            ready_q      <= 1'b0;
            load_err_q   <= 1'b0;
            rom_bytes_q  <= '0;
            rom_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rom_we_q     <= rom_we_d;
            rom_addr_q   <= rom_addr_d;
            rom_data_q   <= rom_data_d;
            tno_q        <= tno_d;
            dsw_q        <= dsw_d;
            core_rst_q   <= core_rst_d;
            ready_q      <= ready_d;
            load_err_q   <= load_err_d;
            rom_bytes_q  <= rom_bytes_d;
            rom_loaded_q <= rom_loaded_d;
        end
    end

    assign bus.rom_we   = rom_we_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_data = rom_data_q;
    assign tno          = tno_q;
    assign dsw          = dsw_q;
    assign core_rst     = core_rst_q;
    assign ready        = ready_q;
    assign load_err     = load_err_q;
    assign rom_bytes    = rom_bytes_q;

endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Sits between the HPS download stream (hps_io ioctl_* signals) and the game core (fpga_druaga).
- Routes ROM bytes to the core ROM write port and captures the title-number byte and the DIP-switch file bytes.
- Sequences the core reset: the core is held in reset until a ROM set has loaded, through every re-download, and for a settle window after any download or user reset.
- Replaces the ad-hoc tno/sw capture and the iRST OR-ing in the top level.

Parameters:
- SETTLE_CYCLES, 1024: core reset hold, in clk_sys cycles, after a download ends or a user reset is released (must be >= 2).
- MAX_TNO, 5: highest legal title number.
- ROM_INDEX, 0: ioctl_index value for ROM data.
- TNO_INDEX, 1: ioctl_index value for the title-number byte.
- DIP_INDEX, 254: ioctl_index value for the DIP-switch file.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high; clears all state.
- ioctl_download  in  1  download session active.
- ioctl_wr  in  1  byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  file index.
- user_rst  in  1  OR of menu reset and the OSD button.
- rom_we  out  1  ROM write strobe to the core.
- rom_addr  out  25  ROM write address.
- rom_data  out  8  ROM write data.
- tno  out  4  captured title number.
- dsw  out  24  DIP bytes {byte2, byte1, byte0}.
- core_rst  out  1  reset to the game core.
- ready  out  1  core running.
- load_err  out  1  bad title byte in the last session.
- rom_bytes  out  25  ROM bytes written in the last or current session.

Behaviour:
- Clock and reset: one clock, clk_sys. Reset is synchronous and active-high on RESET. RESET wins over every simultaneous event.
- Reset values: state EMPTY; rom_we=0; rom_addr=0; rom_data=0; tno=0; dsw=0; core_rst=1; ready=0; load_err=0; rom_bytes=0; rom_loaded=0; settle counter=0.
- Accepted byte: ioctl_wr & ioctl_download. A strobe while ioctl_download=0 is ignored.
- ROM path (index == ROM_INDEX): registered, 1-cycle latency. rom_we pulses exactly one cycle per accepted byte; rom_addr and rom_data capture ioctl_addr and ioctl_dout on that cycle. Each such byte increments rom_bytes (saturates at all-ones) and sets rom_loaded (sticky until RESET).
- Title byte (index == TNO_INDEX):
  - ioctl_dout[3:0] <= MAX_TNO: tno takes that value.
  - Otherwise: tno becomes 0 and load_err is set.
  - A later title byte in the same session overrides an earlier one.
- DIP file (index == DIP_INDEX): only ioctl_addr 0..2 write dsw bytes 0..2 (byte n = dsw[8n+7:8n]). All other addresses are ignored.
- Other index values: ignored.
- On LOAD entry: rom_bytes and load_err clear. tno and dsw keep their values.
- FSM states and transitions:
  - EMPTY: ioctl_download=1 -> LOAD.
  - LOAD: ioctl_download=0 -> SETTLE if rom_loaded, else EMPTY. A DIP-only download before any ROM returns to EMPTY.
  - SETTLE: ioctl_download=1 -> LOAD. user_rst=1 holds the counter at 0. When the counter reaches SETTLE_CYCLES-1 -> RUN. The counter clears on entry.
  - RUN: ioctl_download=1 -> LOAD (priority over user_rst). user_rst=1 -> SETTLE.
- Outputs from the FSM: core_rst=1 in every state except RUN; ready = (state==RUN). Both are registered from the next-state value, so they change in the same cycle as the state.
- Boundary cases:
  - ioctl_download falling in the same cycle as a final ioctl_wr: the byte is still rejected, because acceptance requires ioctl_download=1.
  - user_rst held permanently: the block stays in SETTLE.
  - RESET mid-LOAD: returns to EMPTY with rom_loaded=0; a full reload is required.

Decomposition:
- Shared package druaga_pkg holds:
  - the state enum {EMPTY, LOAD, SETTLE, RUN};
  - index localparams ROM_INDEX, TNO_INDEX, DIP_INDEX;
  - TNO_W=4 and DSW_W=24.
- The block is one module with no sub-module; the settle counter is inline.

Test Plan:
- Reset then idle 100 cycles -> core_rst=1, ready=0, tno=0, dsw=0, rom_bytes=0.
- Session index 1 with byte 0x02, then index 0 with 16 bytes (addr 0..15, data 0xA0+n), download drops -> tno=2; 16 rom_we pulses, each 1 cycle after its ioctl_wr, with matching addr/data; rom_bytes=16; core_rst falls exactly SETTLE_CYCLES cycles after download falls; ready=1.
- Title byte 0x09 with MAX_TNO=5 -> tno=0, load_err=1; next session start clears load_err.
- Index 254 bytes 0x11,0x22,0x33,0x44 at addr 0..3 -> dsw=0x332211; the addr-3 byte is ignored; with no ROM ever loaded the FSM returns to EMPTY and core_rst stays 1.
- In RUN, pulse user_rst 5 cycles -> core_rst=1 immediately; counter held during the pulse; core_rst=0 SETTLE_CYCLES cycles after user_rst falls.
- Assert RESET mid-LOAD, then drive an ioctl_wr with ioctl_download=0 -> state EMPTY, rom_loaded=0, no rom_we pulse.
